cmos_i2c_arbiter: RTL and testbench

Shares the single `i2c_control` register-access engine between two requesters: port 0, the power-up init sequencer, and port 1, the runtime register port (exposure/gain tuning, ID readback). It arbitrates round-robin and issues one-cycle write/read strobes to `i2c_control`. It retries NACKed transfers, times out hung transfers, and returns per-port done/error/read-data. It sits between the camera-config logic and `i2c_control`, replacing direct strobe drive.

---
 rtl/cmos_i2c_arbiter_if.sv | 49 ++++
 rtl/cmos_i2c_arbiter.sv | 127 ++++++++++++
 tb/tb_cmos_i2c_arbiter.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cmos_i2c_arbiter_if.sv
// Signal bundle between cmos_i2c_arbiter, its two requester ports and i2c_control.
// The slave modport is the arbiter's view; master is the surrounding logic's view.
interface cmos_i2c_arbiter_if;
  logic        m0_wr_req;
  logic        m0_rd_req;
  logic [15:0] m0_addr;
  logic [7:0]  m0_wrdata;
  logic [7:0]  m0_rddata;
  logic        m0_done;
  logic        m0_err;

  logic        m1_wr_req;
  logic        m1_rd_req;
  logic [15:0] m1_addr;
  logic [7:0]  m1_wrdata;
  logic [7:0]  m1_rddata;
  logic        m1_done;
  logic        m1_err;

  logic        wrreg_req;
  logic        rdreg_req;
  logic [15:0] addr;
  logic [7:0]  wrdata;
  logic [7:0]  rddata;
  logic        RW_Done;
  logic        ack;
  logic        busy;
  logic        owner;

  modport slave (
    input  m0_wr_req, m0_rd_req, m0_addr, m0_wrdata,
    output m0_rddata, m0_done, m0_err,
    input  m1_wr_req, m1_rd_req, m1_addr, m1_wrdata,
    output m1_rddata, m1_done, m1_err,
    output wrreg_req, rdreg_req, addr, wrdata,
    input  rddata, RW_Done, ack,
    output busy, owner
  );

  modport master (
    output m0_wr_req, m0_rd_req, m0_addr, m0_wrdata,
    input  m0_rddata, m0_done, m0_err,
    output m1_wr_req, m1_rd_req, m1_addr, m1_wrdata,
    input  m1_rddata, m1_done, m1_err,
    input  wrreg_req, rdreg_req, addr, wrdata,
    output rddata, RW_Done, ack,
    input  busy, owner
  );
endinterface

// File: rtl/cmos_i2c_arbiter.sv
// Round-robin sharing of one i2c_control engine between the init sequencer (port 0)
// and the runtime register port (port 1), with NACK retry and hung-transfer timeout.
module cmos_i2c_arbiter #(
  parameter int MAX_RETRY   = 3,
  parameter int TIMEOUT_CYC = 100000
) (
  input logic               Clk,
  input logic               Rst_n,
  cmos_i2c_arbiter_if.slave bus
);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, DONE, GAP} state_t;

  state_t        state_q, state_d;
  logic          owner_q, owner_d;
  logic          op_wr_q, op_wr_d;
  logic [15:0]   addr_q, addr_d;
  logic [7:0]    wrdata_q, wrdata_d;
  logic [7:0]    rd0_q, rd0_d;
  logic [7:0]    rd1_q, rd1_d;
  logic          err_q, err_d;
  logic [RW-1:0] retry_q, retry_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          req0, req1, grant;

  assign req0 = bus.m0_wr_req | bus.m0_rd_req;
  assign req1 = bus.m1_wr_req | bus.m1_rd_req;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q  <= IDLE;
      owner_q  <= 1'b1;
      op_wr_q  <= 1'b0;
      addr_q   <= '0;
      wrdata_q <= '0;
      rd0_q    <= '0;
      rd1_q    <= '0;
      err_q    <= 1'b0;
      retry_q  <= '0;
      tmo_q    <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      op_wr_q  <= op_wr_d;
      addr_q   <= addr_d;
      wrdata_q <= wrdata_d;
      rd0_q    <= rd0_d;
      rd1_q    <= rd1_d;
      err_q    <= err_d;
      retry_q  <= retry_d;
      tmo_q    <= tmo_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    op_wr_d  = op_wr_q;
    addr_d   = addr_q;
    wrdata_d = wrdata_q;
    rd0_d    = rd0_q;
    rd1_d    = rd1_q;
    err_d    = err_q;
    retry_d  = retry_q;
    tmo_d    = tmo_q;
    grant    = req1;
    unique case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          // On a tie the port that did not go last wins
          grant    = (req0 && req1) ? ~owner_q : req1;
          owner_d  = grant;
          addr_d   = grant ? bus.m1_addr   : bus.m0_addr;
          wrdata_d = grant ? bus.m1_wrdata : bus.m0_wrdata;
          op_wr_d  = grant ? bus.m1_wr_req : bus.m0_wr_req;
          err_d    = 1'b0;
          retry_d  = '0;
          tmo_d    = '0;
          state_d  = ISSUE;
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        if (bus.RW_Done) begin
          if (!bus.ack) begin
            err_d   = 1'b0;
            state_d = DONE;
            if (!op_wr_q) begin
              if (owner_q) rd1_d = bus.rddata;
              else         rd0_d = bus.rddata;
            end
          end else if (retry_q < RW'(MAX_RETRY)) begin
            retry_d = retry_q + RW'(1);
            tmo_d   = '0;
            state_d = ISSUE;
          end else begin
            err_d   = 1'b1;
            state_d = DONE;
          end
        end else if (tmo_q == TW'(TIMEOUT_CYC)) begin
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      DONE:    state_d = GAP;
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign bus.wrreg_req = (state_q == ISSUE) &  op_wr_q;
  assign bus.rdreg_req = (state_q == ISSUE) & ~op_wr_q;
  assign bus.addr      = addr_q;
  assign bus.wrdata    = wrdata_q;
  assign bus.busy      = (state_q != IDLE);
  assign bus.owner     = owner_q;
  assign bus.m0_done   = (state_q == DONE) & ~owner_q;
  assign bus.m1_done   = (state_q == DONE) &  owner_q;
  assign bus.m0_err    = bus.m0_done & err_q;
  assign bus.m1_err    = bus.m1_done & err_q;
  assign bus.m0_rddata = rd0_q;
  assign bus.m1_rddata = rd1_q;
endmodule

// File: tb/tb_cmos_i2c_arbiter.sv
// Randomized scoreboard bench for cmos_i2c_arbiter: per-port drivers, an i2c_control
// responder that also models grant order, and a monitor that checks every done pulse.
`timescale 1ns/1ps
module tb_cmos_i2c_arbiter;
  localparam int MAXR = 3;
  localparam int TO   = 60;

  typedef struct {
    bit          isWr;
    bit          both;
    logic [15:0] addr;
    logic [7:0]  data;
    int          nacks;
    bit          hang;
    int          latency;
    logic [7:0]  rdata;
  } txn_t;

  typedef struct {
    bit         err;
    logic [7:0] rdata;
    int         strobes;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;

  cmos_i2c_arbiter_if bus();

  cmos_i2c_arbiter #(.MAX_RETRY(MAXR), .TIMEOUT_CYC(TO)) dut (
    .Clk  (clk),
    .Rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int         checks = 0;
  int         errors = 0;
  int         cycleCnt = 0;
  exp_t       expQ0[$];
  exp_t       expQ1[$];
  txn_t       cur[2];
  logic [7:0] shadow[2];
  logic [7:0] committed[2];
  logic [1:0] histReq = 2'b00;
  bit         respEn = 1'b1;
  bit         inXfer, pending, lastNack, lastGrant, curPort, gp;
  int         attempt, waitCnt, respCycle, expDone, lastDoneCycle;
  int         injectAt = -1;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, actual, expected, cycleCnt);
    end
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_wrreg_req"}, bus.wrreg_req, 0);
    checkOutput({tag, "_rdreg_req"}, bus.rdreg_req, 0);
    checkOutput({tag, "_addr"},      bus.addr, 0);
    checkOutput({tag, "_wrdata"},    bus.wrdata, 0);
    checkOutput({tag, "_m0_rddata"}, bus.m0_rddata, 0);
    checkOutput({tag, "_m1_rddata"}, bus.m1_rddata, 0);
    checkOutput({tag, "_m0_done"},   bus.m0_done, 0);
    checkOutput({tag, "_m1_done"},   bus.m1_done, 0);
    checkOutput({tag, "_m0_err"},    bus.m0_err, 0);
    checkOutput({tag, "_m1_err"},    bus.m1_err, 0);
    checkOutput({tag, "_busy"},      bus.busy, 0);
    checkOutput({tag, "_owner"},     bus.owner, 1);
  endtask

  function automatic txn_t mkTxn(input bit isWr, input bit both, input logic [15:0] a,
                                 input logic [7:0] d, input int nacks, input bit hang,
                                 input int lat, input logic [7:0] rd);
    txn_t t;
    t.isWr = isWr; t.both = both; t.addr = a; t.data = d;
    t.nacks = nacks; t.hang = hang; t.latency = lat; t.rdata = rd;
    return t;
  endfunction

  function automatic txn_t randTxn();
    txn_t t;
    int   r;
    r         = int'($urandom_range(0, 2));
    t.isWr    = (r != 1);
    t.both    = (r == 2);
    t.addr    = 16'($urandom);
    t.data    = 8'($urandom);
    t.rdata   = 8'($urandom);
    r         = int'($urandom_range(0, 19));
    t.hang    = (r == 0);
    t.nacks   = (r < 12) ? 0 : (r < 18) ? int'($urandom_range(1, MAXR)) : MAXR + 1;
    t.latency = int'($urandom_range(0, 8));
    return t;
  endfunction

  // One requester transaction: predict the outcome, raise req, hold it until done.
  task automatic applyStimulus(input int p, input txn_t t, input int idle);
    exp_t e;
    int   n;
    bit   got;
    repeat (idle) @(negedge clk);
    e.err     = t.hang || (t.nacks > MAXR);
    e.strobes = t.hang ? 1 : ((t.nacks > MAXR) ? MAXR + 1 : t.nacks + 1);
    if (!e.err && !t.isWr) shadow[p] = t.rdata;
    e.rdata = shadow[p];
    cur[p]  = t;
    if (p == 0) begin
      expQ0.push_back(e);
      bus.m0_addr = t.addr; bus.m0_wrdata = t.data;
      bus.m0_wr_req = t.isWr; bus.m0_rd_req = !t.isWr || t.both;
    end else begin
      expQ1.push_back(e);
      bus.m1_addr = t.addr; bus.m1_wrdata = t.data;
      bus.m1_wr_req = t.isWr; bus.m1_rd_req = !t.isWr || t.both;
    end
    n = 0;
    got = 1'b0;
    while (!got && n < 3000) begin
      @(negedge clk);
      got = (p == 0) ? bus.m0_done : bus.m1_done;
      n++;
    end
    checkOutput(p == 0 ? "m0_done_in_budget" : "m1_done_in_budget", got, 1);
    if (p == 0) begin bus.m0_wr_req = 1'b0; bus.m0_rd_req = 1'b0; end
    else        begin bus.m1_wr_req = 1'b0; bus.m1_rd_req = 1'b0; end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      cycleCnt++;
      histReq = {bus.m1_wr_req | bus.m1_rd_req, bus.m0_wr_req | bus.m0_rd_req};
    end
  end

  // i2c_control model plus the round-robin expectation for each new grant
  initial begin
    bus.RW_Done = 1'b0;
    bus.ack     = 1'b0;
    bus.rddata  = 8'h00;
    forever begin
      @(negedge clk);
      if (!respEn) begin
        bus.RW_Done = (cycleCnt == injectAt);
        bus.ack     = 1'b0;
        bus.rddata  = 8'hC3;
        continue;
      end
      if (!rst_n) begin
        pending = 0; inXfer = 0; lastGrant = 1; lastNack = 0; attempt = 0;
        lastDoneCycle = -100; expDone = -1;
        bus.RW_Done = 1'b0; bus.ack = 1'b0;
        continue;
      end
      bus.RW_Done = 1'b0;
      bus.ack     = 1'b0;
      if (bus.m0_done || bus.m1_done) begin
        inXfer = 0;
        lastDoneCycle = cycleCnt;
      end
      if (pending) begin
        if (waitCnt == 0) begin
          pending     = 0;
          lastNack    = (attempt < cur[curPort].nacks);
          bus.RW_Done = 1'b1;
          bus.ack     = lastNack;
          bus.rddata  = lastNack ? 8'($urandom) : cur[curPort].rdata;
          respCycle   = cycleCnt;
          if (!lastNack || attempt >= MAXR) expDone = cycleCnt + 1;
        end else begin
          waitCnt--;
        end
      end
      if (bus.wrreg_req || bus.rdreg_req) begin
        if (!inXfer) begin
          checkOutput("grant_has_req", histReq[0] | histReq[1], 1);
          if (histReq[0] && histReq[1]) gp = !lastGrant;
          else                          gp = histReq[1];
          lastGrant = gp; curPort = gp; inXfer = 1; attempt = 0;
          checkOutput("grant_owner", bus.owner, gp);
          checkOutput("grant_spacing", (cycleCnt - lastDoneCycle) >= 3, 1);
        end else begin
          attempt++;
          checkOutput("retry_after_nack", lastNack, 1);
          checkOutput("retry_timing", cycleCnt, respCycle + 1);
        end
        checkOutput("strobe_addr", bus.addr, cur[curPort].addr);
        checkOutput("strobe_wrdata", bus.wrdata, cur[curPort].data);
        checkOutput("strobe_is_wr", bus.wrreg_req, cur[curPort].isWr);
        checkOutput("strobe_single", bus.wrreg_req & bus.rdreg_req, 0);
        if (cur[curPort].hang) expDone = cycleCnt + TO + 2;
        else begin pending = 1; waitCnt = cur[curPort].latency; end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        checkOutput("err_only_with_done", (bus.m0_err & ~bus.m0_done) | (bus.m1_err & ~bus.m1_done), 0);
        if (bus.m0_done || bus.m1_done) checkOutput("done_onehot", bus.m0_done & bus.m1_done, 0);
        for (int p = 0; p < 2; p++) begin
          logic       dn, er;
          logic [7:0] rd, other;
          int         qs;
          exp_t       e;
          dn    = (p == 0) ? bus.m0_done   : bus.m1_done;
          er    = (p == 0) ? bus.m0_err    : bus.m1_err;
          rd    = (p == 0) ? bus.m0_rddata : bus.m1_rddata;
          other = (p == 0) ? bus.m1_rddata : bus.m0_rddata;
          qs    = (p == 0) ? expQ0.size()  : expQ1.size();
          if (dn) begin
            checkOutput("done_expected", qs > 0, 1);
            if (qs > 0) begin
              e = (p == 0) ? expQ0.pop_front() : expQ1.pop_front();
              checkOutput("done_err", er, e.err);
              checkOutput("done_rddata", rd, e.rdata);
              checkOutput("other_rddata_held", other, committed[1 - p]);
              checkOutput("strobe_count", attempt + 1, e.strobes);
              checkOutput("done_cycle", cycleCnt, expDone);
              checkOutput("done_owner", bus.owner, p);
              checkOutput("done_busy", bus.busy, 1);
              committed[p] = e.rdata;
            end
          end
        end
      end
    end
  end

  initial begin
    bit sawDone, sawBusy;
    int n;
    rst_n = 1'b0;
    bus.m0_wr_req = 0; bus.m0_rd_req = 0; bus.m0_addr = 0; bus.m0_wrdata = 0;
    bus.m1_wr_req = 0; bus.m1_rd_req = 0; bus.m1_addr = 0; bus.m1_wrdata = 0;
    shadow[0] = 0; shadow[1] = 0; committed[0] = 0; committed[1] = 0;
    repeat (3) @(negedge clk);
    checkResetState("por");
    rst_n = 1'b1;
    @(negedge clk);

    applyStimulus(0, mkTxn(1, 0, 16'h0012, 8'h80, 0, 0, 50, 8'h00), 1);
    applyStimulus(1, mkTxn(0, 0, 16'h000A, 8'h3C, 0, 0, 3, 8'h77), 1);
    fork
      for (int i = 0; i < 3; i++) applyStimulus(0, mkTxn(1, 0, 16'($urandom), 8'($urandom), 0, 0, 2, 8'h00), 1);
      for (int j = 0; j < 3; j++) applyStimulus(1, mkTxn(0, 0, 16'($urandom), 8'($urandom), 0, 0, 1, 8'($urandom)), 1);
    join
    fork
      applyStimulus(0, mkTxn(1, 0, 16'h3001, 8'h11, MAXR + 2, 0, 1, 8'h00), 1);
      applyStimulus(1, mkTxn(0, 0, 16'h0042, 8'h00, 0, 0, 0, 8'hA5), 4);
    join
    applyStimulus(0, mkTxn(0, 0, 16'h0100, 8'h00, 0, 1, 0, 8'h00), 1);

    fork
      for (int i = 0; i < 30; i++) applyStimulus(0, randTxn(), int'($urandom_range(1, 4)));
      for (int j = 0; j < 30; j++) applyStimulus(1, randTxn(), int'($urandom_range(1, 4)));
    join
    repeat (5) @(negedge clk);
    checkOutput("queues_drained", expQ0.size() + expQ1.size(), 0);

    // Reset in the middle of a transfer, then a late RW_Done from i2c_control
    respEn = 1'b0;
    @(negedge clk);
    bus.m0_addr = 16'h1234; bus.m0_wrdata = 8'h5A; bus.m0_wr_req = 1'b1;
    n = 0;
    while (!bus.wrreg_req && n < 20) begin @(negedge clk); n++; end
    checkOutput("rst_test_strobe", bus.wrreg_req, 1);
    repeat (2) @(negedge clk);
    checkOutput("rst_test_busy_before", bus.busy, 1);
    rst_n = 1'b0;
    bus.m0_wr_req = 1'b0;
    #1;
    checkResetState("midxfer");
    @(negedge clk);
    rst_n = 1'b1;
    injectAt = cycleCnt + 1;
    sawDone = 0;
    sawBusy = 0;
    repeat (6) begin
      @(negedge clk);
      sawDone |= bus.m0_done | bus.m1_done;
      sawBusy |= bus.busy;
    end
    checkOutput("rst_no_done", sawDone, 0);
    checkOutput("rst_stays_idle", sawBusy, 0);
    checkOutput("rst_owner", bus.owner, 1);
    checkOutput("rst_m0_rddata", bus.m0_rddata, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
